pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
- Next-generation program counter for the soft processor: one register block combining the PC register and next-PC selection.
- Parametrised PC width. Adds stall, absolute jump, and call/return through an internal return-address stack (RAS) with overflow/underflow detection.
- Sits between the control decoder (which supplies op, cond, offset and target) and instruction memory (which consumes pc).
- Word-addressed: sequential fetch adds 1.

Parameters:
- PC_W, 32, width of pc, offset, target and RAS entries.
- RAS_DEPTH, 8, number of RAS entries; power of two, minimum 2.
- RESET_PC, 0, value loaded into pc on reset.
- TRAP_PC, 0, redirect address used only when PC_TRAP_EN is defined.

Ports:
- clk  in  1  processor clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold pc and RAS unchanged this cycle.
- op  in  3  0=NEXT, 1=BRANCH, 2=JUMP, 3=CALL, 4=RET, 5..7 behave as NEXT.
- cond  in  1  branch condition; used only by BRANCH.
- offset  in  PC_W  signed two's-complement relative displacement.
- target  in  PC_W  absolute destination for JUMP and CALL.
- pc  out  PC_W  current program counter.
- ras_empty  out  1  RAS holds 0 entries (combinational from the stack pointer).
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: a CALL occurred while the RAS was full.
- ras_unf  out  1  sticky: a RET occurred while the RAS was empty.

Behaviour:
- Reset (async, any time, including mid-stall):
  - pc=RESET_PC; stack pointer=0, so ras_empty=1 and ras_full=0.
  - ras_ovf=0, ras_unf=0. RAS contents are don't-care.
- Latency: pc updates on every non-stalled falling edge. Inputs are sampled at that edge; the new pc is visible immediately after it.
- stall=1: pc, stack pointer, RAS contents and sticky flags all hold; op is ignored.
- Next-pc selection, with seq = pc+1 in modulo-2^PC_W arithmetic:
  - NEXT: pc <= seq.
  - BRANCH: pc <= cond ? pc+1+offset : seq. Offset is sign-extended and the sum wraps modulo 2^PC_W. Example: offset=-1 gives pc unchanged, i.e. a self-loop.
  - JUMP: pc <= target.
  - CALL, not full: push seq; sp <= sp+1; pc <= target.
  - CALL, full: pc <= target; push is dropped; contents and sp are unchanged; ras_ovf <= 1.
  - RET, not empty: pc <= top entry; sp <= sp-1.
  - RET, empty: pc <= seq; sp stays 0; ras_unf <= 1.
- Sticky flags clear only on rst.
- Wrap-around: pc=2^PC_W-1 with NEXT gives pc=0. No flag is raised.
- RAS is LIFO. The top entry is at index sp-1. Storage may be a register array; no reads of invalid entries are visible at the ports.

Optional Feature:
- Macro PC_TRAP_EN.
- When defined: CALL-when-full and RET-when-empty load pc <= TRAP_PC instead of the rules above. The sticky flags are still set. The RAS is left unchanged.
- When undefined: behaviour is exactly as in Behaviour, and TRAP_PC is unused.

Decomposition:
- Shared package pc_pkg holds:
  - op encoding constants PC_OP_NEXT, PC_OP_BRANCH, PC_OP_JUMP, PC_OP_CALL, PC_OP_RET;
  - the op width constant (3);
  - default PC_W.
- One natural sub-module, pc_ras: parametrised by PC_W and RAS_DEPTH.
  - Ports: clk, rst, push, pop, din, dout, empty, full.
  - It ignores a push when full and a pop when empty.
- The top level holds the pc register, next-pc mux and sticky flags.

Test Plan:
- Reset, then 4 cycles of NEXT: pc 0,1,2,3,4. Assert rst mid-sequence (not on a clock edge): pc=0 immediately.
- pc=10, BRANCH cond=1 offset=-3: pc=8. pc=10, BRANCH cond=1 offset=+5: pc=16. BRANCH cond=0: pc=11.
- pc=5, CALL target=100: pc=100, ras_empty=0. Then NEXT twice: pc=102. Then RET: pc=6, ras_empty=1.
- RAS_DEPTH=2, three nested CALLs: ras_full=1 after the second, ras_ovf=1 after the third. Then RETs return the first two pushed addresses in LIFO order. A third RET sets ras_unf=1 and gives pc=pc+1 (or TRAP_PC with PC_TRAP_EN).
- stall=1 held 3 cycles with op=CALL: pc, sp and flags are unchanged. Release stall: the CALL takes effect once.
- PC_W=8, pc=255, NEXT: pc=0. Then BRANCH cond=1 offset=-2 from pc=0: pc=255.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencing unit:
// operation encodings, operation width and the default PC width.
package pc_pkg;

    // Width of the op field supplied by the control decoder
    localparam int PC_OP_W = 3;

    // Default program-counter width
    localparam int PC_W_DEFAULT = 32;

    // Next-pc operation encodings; codes 5..7 fall back to NEXT
    localparam logic [PC_OP_W-1:0] PC_OP_NEXT   = 3'd0;
    localparam logic [PC_OP_W-1:0] PC_OP_BRANCH = 3'd1;
    localparam logic [PC_OP_W-1:0] PC_OP_JUMP   = 3'd2;
    localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'd3;
    localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'd4;

endpackage

// File: rtl/pc_seq_unit_ras.sv
// Return-address stack for pc_seq_unit: a small LIFO of PC values.
// A push while full and a pop while empty are silently ignored; the
// parent is responsible for flagging those events. State changes on the
// falling clock edge to match the rest of the sequencing unit.
module pc_ras
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            empty,
    output logic            full
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [PC_W-1:0]  entries_q [RAS_DEPTH];
    logic [PC_W-1:0]  entries_d [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    // The stack pointer counts valid entries; the top lives at sp-1.
    // When empty, top_idx wraps inside the array, so dout is a harmless
    // stale value that the parent never selects.
    assign wr_idx  = sp_q[IDX_W-1:0];
    assign top_idx = wr_idx - IDX_W'(1);
    assign dout    = entries_q[top_idx];
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_W'(RAS_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next stack state; push wins if both requests ever arrive together
    always_comb begin
        entries_d = entries_q;
        sp_d      = sp_q;
        if (do_push) begin
            entries_d[wr_idx] = din;
            sp_d              = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    // Stack storage and pointer, updated on the falling edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            sp_q      <= sp_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter and next-pc selection for the soft processor.
// Supports sequential fetch, conditional relative branch, absolute jump
// and call/return through an internal return-address stack, with sticky
// overflow/underflow flags. All state changes on the falling clock edge.
// Optional feature macro PC_TRAP_EN: a CALL while the stack is full or a
// RET while it is empty redirects pc to TRAP_PC instead of the normal
// destination.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEFAULT,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [PC_W-1:0] TRAP_PC   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [PC_OP_W-1:0] op,
    input  logic               cond,
    input  logic [PC_W-1:0]    offset,
    input  logic [PC_W-1:0]    target,
    output logic [PC_W-1:0]    pc,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_ovf,
    output logic               ras_unf
);

`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            is_call;
    logic            is_ret;
    logic            call_ovf;
    logic            ret_unf;

    assign seq_pc   = pc_q + PC_W'(1);
    assign is_call  = !stall && (op == PC_OP_CALL);
    assign is_ret   = !stall && (op == PC_OP_RET);
    assign call_ovf = is_call && ras_full;
    assign ret_unf  = is_ret && ras_empty;
    assign ras_push = is_call && !ras_full;
    assign ras_pop  = is_ret && !ras_empty;

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq_pc),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Next-pc mux and sticky flag update; a stall freezes everything
    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q | call_ovf;
        unf_d = unf_q | ret_unf;
        if (!stall) begin
            case (op)
                PC_OP_BRANCH: pc_d = cond ? (seq_pc + offset) : seq_pc;
                PC_OP_JUMP:   pc_d = target;
                PC_OP_CALL:   pc_d = (call_ovf && TRAP_EN) ? TRAP_PC : target;
                PC_OP_RET: begin
                    if (ret_unf) begin
                        pc_d = TRAP_EN ? TRAP_PC : seq_pc;
                    end else begin
                        pc_d = ras_top;
                    end
                end
                default:      pc_d = seq_pc;
            endcase
        end
    end

    // Program counter and sticky flags, updated on the falling edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit (PC_W=8, RAS_DEPTH=2). Stimulus pushes
// hand-computed expectations into a queue; a monitor pops and compares on
// each rising edge (state changes on the falling edge) or on demand for
// asynchronous-reset checks.
module tb_pc_seq_unit;

    localparam int PC_W = 8;

`ifdef PC_TRAP_EN
    localparam logic [PC_W-1:0] OVF_PC = 8'd0;
    localparam logic [PC_W-1:0] UNF_PC = 8'd0;
`else
    localparam logic [PC_W-1:0] OVF_PC = 8'd60;
    localparam logic [PC_W-1:0] UNF_PC = 8'd8;
`endif

    typedef struct {
        string           name;
        logic [PC_W-1:0] pc;
        logic            empty;
        logic            full;
        logic            ovf;
        logic            unf;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            stall;
    logic [2:0]      op;
    logic            cond;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;

    exp_t exp_q[$];
    event check_ev;
    int   vectors = 0;
    int   miscompares = 0;

    pc_seq_unit #(
        .PC_W      (PC_W),
        .RAS_DEPTH (2),
        .RESET_PC  (8'd0),
        .TRAP_PC   (8'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .op        (op),
        .cond      (cond),
        .offset    (offset),
        .target    (target),
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    // Free-running clock: falling edges at 5,15,..., rising at 10,20,...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Monitor: compare the oldest expectation against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or check_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (pc !== e.pc || ras_empty !== e.empty || ras_full !== e.full ||
                    ras_ovf !== e.ovf || ras_unf !== e.unf) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got pc=%0d empty=%b full=%b ovf=%b unf=%b, expected pc=%0d empty=%b full=%b ovf=%b unf=%b",
                             e.name, pc, ras_empty, ras_full, ras_ovf, ras_unf,
                             e.pc, e.empty, e.full, e.ovf, e.unf);
                end
            end
        end
    end

    function automatic void push_exp(input string name, input logic [PC_W-1:0] p,
                                     input logic em, input logic fu,
                                     input logic ov, input logic un);
        exp_t e;
        e.name  = name;
        e.pc    = p;
        e.empty = em;
        e.full  = fu;
        e.ovf   = ov;
        e.unf   = un;
        exp_q.push_back(e);
    endfunction

    // Drive one cycle of inputs (called just after a rising edge) and
    // queue the state expected after the following falling edge
    task automatic apply_stimulus(input string name, input logic stl, input logic [2:0] o,
                                  input logic c, input logic [PC_W-1:0] off,
                                  input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] p,
                                  input logic em, input logic fu,
                                  input logic ov, input logic un);
        stall  = stl;
        op     = o;
        cond   = c;
        offset = off;
        target = tgt;
        push_exp(name, p, em, fu, ov, un);
        @(posedge clk);
        #1;
    endtask

    // Immediate check, used for asynchronous reset
    task automatic check_now(input string name, input logic [PC_W-1:0] p,
                             input logic em, input logic fu,
                             input logic ov, input logic un);
        push_exp(name, p, em, fu, ov, un);
        ->check_ev;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; op = 3'd0; cond = 1'b0; offset = '0; target = '0;
        #2;
        check_now("reset", 8'd0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch
        apply_stimulus("next1", 0, 3'd0, 0, 8'd0, 8'd0, 8'd1, 1, 0, 0, 0);
        apply_stimulus("next2", 0, 3'd0, 0, 8'd0, 8'd0, 8'd2, 1, 0, 0, 0);
        apply_stimulus("next3", 0, 3'd7, 0, 8'd0, 8'd0, 8'd3, 1, 0, 0, 0);
        apply_stimulus("next4", 0, 3'd5, 0, 8'd0, 8'd0, 8'd4, 1, 0, 0, 0);

        // Asynchronous reset between edges
        rst = 1'b1;
        #2;
        check_now("mid_reset", 8'd0, 1, 0, 0, 0);
        rst = 1'b0;

        // Branches from pc=10
        apply_stimulus("jump10a",  0, 3'd2, 0, 8'd0,   8'd10, 8'd10, 1, 0, 0, 0);
        apply_stimulus("br_m3",    0, 3'd1, 1, 8'hFD,  8'd0,  8'd8,  1, 0, 0, 0);
        apply_stimulus("jump10b",  0, 3'd2, 0, 8'd0,   8'd10, 8'd10, 1, 0, 0, 0);
        apply_stimulus("br_p5",    0, 3'd1, 1, 8'd5,   8'd0,  8'd16, 1, 0, 0, 0);
        apply_stimulus("jump10c",  0, 3'd2, 0, 8'd0,   8'd10, 8'd10, 1, 0, 0, 0);
        apply_stimulus("br_nt",    0, 3'd1, 0, 8'd5,   8'd0,  8'd11, 1, 0, 0, 0);
        apply_stimulus("br_self",  0, 3'd1, 1, 8'hFF,  8'd0,  8'd11, 1, 0, 0, 0);

        // Single call/return
        apply_stimulus("jump5",    0, 3'd2, 0, 8'd0, 8'd5,   8'd5,   1, 0, 0, 0);
        apply_stimulus("call100",  0, 3'd3, 0, 8'd0, 8'd100, 8'd100, 0, 0, 0, 0);
        apply_stimulus("next101",  0, 3'd0, 0, 8'd0, 8'd0,   8'd101, 0, 0, 0, 0);
        apply_stimulus("next102",  0, 3'd0, 0, 8'd0, 8'd0,   8'd102, 0, 0, 0, 0);
        apply_stimulus("ret6",     0, 3'd4, 0, 8'd0, 8'd0,   8'd6,   1, 0, 0, 0);

        // Nested calls past depth, then returns past empty
        apply_stimulus("call20",   0, 3'd3, 0, 8'd0, 8'd20, 8'd20,  0, 0, 0, 0);
        apply_stimulus("call40",   0, 3'd3, 0, 8'd0, 8'd40, 8'd40,  0, 1, 0, 0);
        apply_stimulus("call_ovf", 0, 3'd3, 0, 8'd0, 8'd60, OVF_PC, 0, 1, 1, 0);
        apply_stimulus("ret21",    0, 3'd4, 0, 8'd0, 8'd0,  8'd21,  0, 0, 1, 0);
        apply_stimulus("ret7",     0, 3'd4, 0, 8'd0, 8'd0,  8'd7,   1, 0, 1, 0);
        apply_stimulus("ret_unf",  0, 3'd4, 0, 8'd0, 8'd0,  UNF_PC, 1, 0, 1, 1);

        // Stall held with CALL pending, then released
        apply_stimulus("jump30",   0, 3'd2, 0, 8'd0, 8'd30,  8'd30,  1, 0, 1, 1);
        apply_stimulus("stall1",   1, 3'd3, 0, 8'd0, 8'd200, 8'd30,  1, 0, 1, 1);
        apply_stimulus("stall2",   1, 3'd3, 0, 8'd0, 8'd200, 8'd30,  1, 0, 1, 1);
        apply_stimulus("stall3",   1, 3'd3, 0, 8'd0, 8'd200, 8'd30,  1, 0, 1, 1);
        apply_stimulus("call200",  0, 3'd3, 0, 8'd0, 8'd200, 8'd200, 0, 0, 1, 1);
        apply_stimulus("ret31",    0, 3'd4, 0, 8'd0, 8'd0,   8'd31,  1, 0, 1, 1);

        // Wrap-around at the top of the address space
        apply_stimulus("jump255",  0, 3'd2, 0, 8'd0,  8'd255, 8'd255, 1, 0, 1, 1);
        apply_stimulus("wrap0",    0, 3'd0, 0, 8'd0,  8'd0,   8'd0,   1, 0, 1, 1);
        apply_stimulus("br_back",  0, 3'd1, 1, 8'hFE, 8'd0,   8'd255, 1, 0, 1, 1);

        // Reset asserted while stalled clears everything
        stall = 1'b1;
        op    = 3'd3;
        rst   = 1'b1;
        #2;
        check_now("stall_reset", 8'd0, 1, 0, 0, 0);
        rst   = 1'b0;
        stall = 1'b0;
        op    = 3'd0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
            miscompares += exp_q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
